// File: rtl/alu_seq_unit.sv
// Sequential RV32I integer ALU. It accepts one OP/OP-IMM instruction at a time.
// Register shifts advance one bit per cycle, and the result is held until the consumer takes it.
module alu_seq_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        illegal,
  output logic [1:0]  dbg_state_o
);

  // Handshakes: an input transfer happens on a rising edge with in_valid && in_ready.
  // An output transfer happens on a rising edge with out_valid && out_ready.
  // out/illegal stay stable while out_valid is high.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SH_LL = 2'd0,
    SH_RL = 2'd1,
    SH_RA = 2'd2
  } shift_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  state_t      state_q;
  shift_t      kind_q;
  logic [4:0]  cnt_q;
  logic [31:0] out_q;
  logic        illegal_q;
  logic        out_valid_q;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        is_op;
  logic        is_imm;
  logic        f7_zero;
  logic        f7_alt;
  logic [4:0]  shamt;
  logic        dec_illegal;
  logic        dec_shift;
  shift_t      dec_kind;
  logic [31:0] alu_res;
  logic [31:0] shift_step;

  assign opcode  = instr[6:0];
  assign f3      = instr[14:12];
  assign f7      = instr[31:25];
  assign is_op   = (opcode == OPC_OP);
  assign is_imm  = (opcode == OPC_OP_IMM);
  assign f7_zero = (f7 == F7_ZERO);
  assign f7_alt  = (f7 == F7_ALT);
  assign shamt   = in2[4:0];

  // For OP-IMM, instr[31:25] is immediate data, except on the shift encodings.
  always_comb begin
    dec_illegal = 1'b1;
    dec_shift   = 1'b0;
    dec_kind    = SH_LL;
    alu_res     = 32'h0;
    if (is_op || is_imm) begin
      case (f3)
        3'b000: begin
          dec_illegal = is_op && !(f7_zero || f7_alt);
          alu_res     = (is_op && f7_alt) ? (in1 - in2) : (in1 + in2);
        end
        3'b001: begin
          dec_illegal = !f7_zero;
          dec_shift   = 1'b1;
          dec_kind    = SH_LL;
          alu_res     = in1;
        end
        3'b101: begin
          dec_illegal = !(f7_zero || f7_alt);
          dec_shift   = 1'b1;
          dec_kind    = f7_alt ? SH_RA : SH_RL;
          alu_res     = in1;
        end
        3'b010: begin
          dec_illegal = is_op && !f7_zero;
          alu_res     = {31'h0, ($signed(in1) < $signed(in2))};
        end
        3'b011: begin
          dec_illegal = is_op && !f7_zero;
          alu_res     = {31'h0, (in1 < in2)};
        end
        3'b100: begin
          dec_illegal = is_op && !f7_zero;
          alu_res     = in1 ^ in2;
        end
        3'b110: begin
          dec_illegal = is_op && !f7_zero;
          alu_res     = in1 | in2;
        end
        default: begin
          dec_illegal = is_op && !f7_zero;
          alu_res     = in1 & in2;
        end
      endcase
    end
  end

  always_comb begin
    case (kind_q)
      SH_RL:   shift_step = {1'b0, out_q[31:1]};
      SH_RA:   shift_step = {out_q[31], out_q[31:1]};
      default: shift_step = {out_q[30:0], 1'b0};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      kind_q      <= SH_LL;
      cnt_q       <= 5'd0;
      out_q       <= 32'h0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (!dec_illegal && dec_shift && (shamt != 5'd0)) begin
              out_q     <= in1;
              cnt_q     <= shamt;
              kind_q    <= dec_kind;
              illegal_q <= 1'b0;
              state_q   <= S_SHIFT;
            end else begin
              out_q       <= dec_illegal ? 32'h0 : alu_res;
              illegal_q   <= dec_illegal;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          out_q <= shift_step;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == S_IDLE) && !reset;
  assign out         = out_q;
  assign out_valid   = out_valid_q;
  assign illegal     = illegal_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: fixed vector table, hand-written corner sequences,
// and random operations checked against a plain-arithmetic model.
module tb_alu_seq_unit;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_w;
  logic        out_valid;
  logic        out_ready;
  logic        illegal;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq_unit dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .in1        (in1),
    .in2        (in2),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out        (out_w),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .illegal    (illegal),
    .dbg_state_o(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] OP  = 7'b0110011;
  localparam logic [6:0] IMM = 7'b0010011;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_out;
    logic        exp_ill;
    int          exp_lat;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
  endfunction

  // Architectural reference: result from the instruction's meaning, latency from shift amount.
  function automatic void model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ill, output int lat);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    int         sh;
    logic       legal;
    logic       alt;
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    sh  = int'(b[4:0]);
    legal = 1'b0;
    if (opc == OP) legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    else if (opc == IMM) begin
      if (f3 == 3'd1) legal = (f7 == 7'h00);
      else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
      else legal = 1'b1;
    end
    alt = (f7 == 7'h20);
    case (f3)
      3'd0: r = (opc == OP && alt) ? a - b : a + b;
      3'd1: r = a << sh;
      3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: r = (a < b) ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: r = alt ? 32'($signed(a) >>> sh) : a >> sh;
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    if (!legal) r = 32'h0;
    ill = !legal;
    lat = (legal && (f3 == 3'd1 || f3 == 3'd5)) ? sh + 1 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  // Called at #1 after a rising edge; returns at #1 after the release edge.
  task automatic run_op(input string name, input logic [31:0] ins, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_out, input logic exp_ill,
                        input int exp_lat, input int hold);
    int budget;
    int lat;
    budget = 0;
    while (!in_ready && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!in_ready) begin
      check({name, " in_ready timeout"}, 32'(in_ready), 32'd1);
      return;
    end
    instr = ins; in1 = a; in2 = b; in_valid = 1'b1;
    out_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      instr = $urandom; in1 = $urandom; in2 = $urandom;
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    if (!out_valid) begin
      check({name, " out_valid timeout"}, 32'(out_valid), 32'd1);
      return;
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " out"}, out_w, exp_out);
    check({name, " illegal"}, 32'(illegal), 32'(exp_ill));
    check({name, " in_ready busy"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      instr = $urandom; in1 = $urandom; in2 = $urandom; in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check({name, " hold state"}, {out_w[31:0] ^ exp_out, 29'h0, out_valid, in_ready, illegal ^ exp_ill}, {32'h0, 29'h0, 1'b1, 1'b0, 1'b0});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, " out_valid after take"}, 32'(out_valid), 32'd0);
    check({name, " in_ready after take"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    logic        ill;
    int          lat;
    logic [31:0] ins;
    logic [6:0]  f7;
    int          cnt;

    vecs[0]  = '{mk(7'h00, 3'd0, OP),  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1};
    vecs[1]  = '{mk(7'h20, 3'd0, OP),  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1};
    vecs[2]  = '{mk(7'h00, 3'd2, OP),  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1};
    vecs[3]  = '{mk(7'h00, 3'd3, OP),  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1};
    vecs[4]  = '{32'h4040D093,          32'h80000000, 32'h00000404, 32'hF8000000, 1'b0, 5};
    vecs[5]  = '{mk(7'h00, 3'd5, OP),  32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 32};
    vecs[6]  = '{mk(7'h00, 3'd1, OP),  32'h00001234, 32'h00000020, 32'h00001234, 1'b0, 1};
    vecs[7]  = '{mk(7'h00, 3'd1, IMM), 32'h80000001, 32'h00000001, 32'h00000002, 1'b0, 2};
    vecs[8]  = '{32'h00000073,          32'h12345678, 32'h00000001, 32'h00000000, 1'b1, 1};
    vecs[9]  = '{mk(7'h20, 3'd4, OP),  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1};
    vecs[10] = '{mk(7'h20, 3'd1, IMM), 32'h00000001, 32'h00000405, 32'h00000000, 1'b1, 1};
    vecs[11] = '{mk(7'h00, 3'd7, IMM), 32'hF0F0F0F0, 32'hFFFFFF0F, 32'hF0F0F000, 1'b0, 1};
    vecs[12] = '{mk(7'h7F, 3'd0, IMM), 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1};
    vecs[13] = '{mk(7'h20, 3'd5, OP),  32'h80000000, 32'hFFFFFFE1, 32'hC0000000, 1'b0, 2};
    vecs[14] = '{mk(7'h00, 3'd4, OP),  32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 1'b0, 1};
    vecs[15] = '{mk(7'h00, 3'd3, IMM), 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1};

    reset = 1'b1; instr = 32'h0; in1 = 32'h0; in2 = 32'h0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset out", out_w, 32'h0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset illegal", 32'(illegal), 32'd0);
    reset = 1'b0;
    #1;
    check("in_ready after reset", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++)
      run_op($sformatf("vec%0d", i), vecs[i].ins, vecs[i].a, vecs[i].b,
             vecs[i].exp_out, vecs[i].exp_ill, vecs[i].exp_lat, 0);

    run_op("sltu backpressure", mk(7'h00, 3'd3, OP), 32'h00000001, 32'hFFFFFFFF,
           32'h00000001, 1'b0, 1, 10);

    // Reset ten cycles into a 31-step shift must discard the operation.
    instr = mk(7'h00, 3'd1, OP); in1 = 32'h1; in2 = 32'h1F; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mid-shift reset out_valid", 32'(out_valid), 32'd0);
    check("mid-shift reset out", out_w, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("in_ready after mid-shift reset", 32'(in_ready), 32'd1);
    cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    check("no stale out_valid after reset", 32'(cnt), 32'd0);
    run_op("add after reset", mk(7'h00, 3'd0, OP), 32'd3, 32'd4, 32'h7, 1'b0, 1, 0);

    // Reset while a result is waiting in the output register.
    instr = mk(7'h00, 3'd0, OP); in1 = 32'd9; in2 = 32'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    cnt = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    check("no out_valid after reset in done", 32'(cnt), 32'd0);

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 3))
        0: f7 = 7'($urandom);
        1: f7 = 7'h20;
        default: f7 = 7'h00;
      endcase
      ins = {f7, 10'($urandom), 3'($urandom), 5'($urandom),
             ($urandom_range(0, 9) == 0) ? 7'($urandom) : (($urandom_range(0, 1) == 1) ? OP : IMM)};
      in1 = $urandom;
      in2 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      model(ins, in1, in2, r, ill, lat);
      run_op($sformatf("rand%0d ins=%08h", n, ins), ins, in1, in2, r, ill, lat,
             ($urandom_range(0, 7) == 0) ? 3 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
